// File: rtl/minimig_sdram_pkg.sv
// Shared definitions for the Minimig chip-RAM to SDRAM port.
// Contents:
//   state_t      - transaction state encoding (IDLE = 0)
//   ADDR_W_DEF   - default word-address width (address bits [22:1])
//   BS_W         - byte-strobe width {hi,lo}
//   phase_q0/q1  - decode of the chipset c1/c3 phase signals
package minimig_sdram_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR1_REQ = 3'd3,
    WR2_REQ = 3'd4
  } state_t;

  localparam int ADDR_W_DEF = 22;
  localparam int BS_W       = 2;

  // Q0: both phase signals low; the chipset expects the access to be over.
  function automatic logic phase_q0(input logic c1, input logic c3);
    return !c1 && !c3;
  endfunction

  // Q1: bridge strobes, address and data are stable and get captured.
  function automatic logic phase_q1(input logic c1, input logic c3);
    return c1 && !c3;
  endfunction

endpackage

// File: rtl/minimig_chipram_sdram_port.sv
// Converts chipset SRAM-bridge accesses into req/ack SDRAM transactions.
// Ports:
//   clk, _reset             - 28 MHz clock, synchronous active-low reset
//   c1, c3                  - chipset phase signals (Q1 captures, Q0 is the deadline)
//   _we, _oe                - bridge write / output enables (active-low)
//   _bhe/_ble, _bhe2/_ble2  - first / second word byte enables (active-low)
//   address, data, data2    - word address and write data for both words
//   ramdata_in              - read data returned to the bridge
//   sd_req/sd_we/sd_addr/sd_wdata/sd_bs, sd_ack, sd_rdata, sd_rvalid
//                           - SDRAM controller request/acknowledge port
//   busy                    - a transaction is in flight
//   late, late_cnt          - deadline-miss pulse and its saturating count
module minimig_chipram_sdram_port
  import minimig_sdram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              c1,
  input  logic              c3,
  input  logic              _we,
  input  logic              _oe,
  input  logic              _bhe,
  input  logic              _ble,
  input  logic              _bhe2,
  input  logic              _ble2,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       data,
  input  logic [15:0]       data2,
  output logic [15:0]       ramdata_in,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_wdata,
  output logic [BS_W-1:0]   sd_bs,
  input  logic              sd_ack,
  input  logic [15:0]       sd_rdata,
  input  logic              sd_rvalid,
  output logic              busy,
  output logic              late,
  output logic [7:0]        late_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t              state_q;
  logic                sd_req_q, sd_we_q, late_q;
  logic [ADDR_W-1:0]   sd_addr_q;
  logic [15:0]         sd_wdata_q, ramdata_q, data2_q;
  logic [BS_W-1:0]     sd_bs_q, bs2_q;
  logic [7:0]          late_cnt_q;
  logic [WAIT_W-1:0]   wait_q;

  logic                q0, q1, wr_access, rd_access, advance, timeout, late_d;
  logic [BS_W-1:0]     bs1_in, bs2_in;

  always_comb begin
    q0        = phase_q0(c1, c3);
    q1        = phase_q1(c1, c3);
    bs1_in    = {!_bhe, !_ble};
    bs2_in    = {!_bhe2, !_ble2};
    // A write with no byte enabled is not a write; it may still be a read.
    wr_access = !_we && ((|bs1_in) || (|bs2_in));
    rd_access = !wr_access && !_oe;
    // advance = the state changes this cycle, which restarts the wait counter.
    case (state_q)
      RD_REQ:  advance = sd_ack;
      RD_WAIT: advance = sd_rvalid;
      WR1_REQ: advance = sd_ack;
      WR2_REQ: advance = sd_req_q && sd_ack;  // ack during the req gap is ignored
      default: advance = 1'b0;
    endcase
    timeout = (state_q != IDLE) && !advance && (wait_q == WAIT_W'(TIMEOUT - 1));
    // Several causes in one cycle collapse into a single pulse.
    late_d  = (state_q != IDLE) && (q0 || q1 || timeout);
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q    <= IDLE;
      sd_req_q   <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      sd_bs_q    <= '0;
      bs2_q      <= '0;
      data2_q    <= '0;
      ramdata_q  <= '0;
      late_q     <= 1'b0;
      late_cnt_q <= '0;
      wait_q     <= '0;
    end else begin
      late_q <= late_d;
      if (late_d && (late_cnt_q != 8'hFF)) late_cnt_q <= late_cnt_q + 8'd1;

      if ((state_q == IDLE) || advance || timeout) wait_q <= '0;
      else                                         wait_q <= wait_q + WAIT_W'(1);

      if (timeout) begin
        state_q  <= IDLE;
        sd_req_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (q1 && wr_access) begin
              sd_we_q  <= 1'b1;
              sd_req_q <= 1'b1;
              bs2_q    <= bs2_in;
              data2_q  <= data2;
              if (|bs1_in) begin
                state_q    <= WR1_REQ;
                sd_addr_q  <= address;
                sd_bs_q    <= bs1_in;
                sd_wdata_q <= data;
              end else begin
                // Only the second word is written: start at address+1.
                state_q    <= WR2_REQ;
                sd_addr_q  <= address + ADDR_W'(1);
                sd_bs_q    <= bs2_in;
                sd_wdata_q <= data2;
              end
            end else if (q1 && rd_access) begin
              state_q   <= RD_REQ;
              sd_req_q  <= 1'b1;
              sd_we_q   <= 1'b0;
              sd_addr_q <= address;
              sd_bs_q   <= '1;
            end
          end
          RD_REQ: begin
            if (sd_ack) begin
              sd_req_q <= 1'b0;
              if (sd_rvalid) begin
                ramdata_q <= sd_rdata;
                state_q   <= IDLE;
              end else begin
                state_q   <= RD_WAIT;
              end
            end
          end
          RD_WAIT: begin
            if (sd_rvalid) begin
              ramdata_q <= sd_rdata;
              state_q   <= IDLE;
            end
          end
          WR1_REQ: begin
            if (sd_ack) begin
              sd_req_q <= 1'b0;
              if (|bs2_q) begin
                // Load the second word now; WR2_REQ re-raises req a cycle later.
                state_q    <= WR2_REQ;
                sd_addr_q  <= sd_addr_q + ADDR_W'(1);
                sd_bs_q    <= bs2_q;
                sd_wdata_q <= data2_q;
              end else begin
                state_q    <= IDLE;
              end
            end
          end
          WR2_REQ: begin
            if (!sd_req_q) begin
              sd_req_q <= 1'b1;
            end else if (sd_ack) begin
              sd_req_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ramdata_in = ramdata_q;
  assign sd_req     = sd_req_q;
  assign sd_we      = sd_we_q;
  assign sd_addr    = sd_addr_q;
  assign sd_wdata   = sd_wdata_q;
  assign sd_bs      = sd_bs_q;
  assign busy       = (state_q != IDLE);
  assign late       = late_q;
  assign late_cnt   = late_cnt_q;

endmodule

// File: tb/tb_minimig_chipram_sdram_port.sv
// Self-checking bench for minimig_chipram_sdram_port. The bench plays the
// bridge and the SDRAM controller; expected requests are derived from the
// access rules (which words get written, at which address, with which strobes).
module tb_minimig_chipram_sdram_port;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          _reset, c1, c3, _we, _oe, _bhe, _ble, _bhe2, _ble2;
  logic [AW-1:0] address, sd_addr;
  logic [15:0]   data, data2, ramdata_in, sd_wdata, sd_rdata;
  logic          sd_req, sd_we, sd_ack, sd_rvalid, busy, late;
  logic [1:0]    sd_bs;
  logic [7:0]    late_cnt;

  int            total = 0;
  int            bad   = 0;
  logic [15:0]   exp_ram;
  int            exp_late;

  always #5 clk = ~clk;

  minimig_chipram_sdram_port #(.ADDR_W(AW), .TIMEOUT(15)) dut (
    .clk(clk), ._reset(_reset), .c1(c1), .c3(c3), ._we(_we), ._oe(_oe),
    ._bhe(_bhe), ._ble(_ble), ._bhe2(_bhe2), ._ble2(_ble2),
    .address(address), .data(data), .data2(data2), .ramdata_in(ramdata_in),
    .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_bs(sd_bs), .sd_ack(sd_ack), .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid),
    .busy(busy), .late(late), .late_cnt(late_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_late(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // One Q1 cycle with the given bridge signals, then back to a quiet bus in Q2.
  task automatic q1_pulse(input logic we_n, input logic oe_n, input logic bhe_n,
                          input logic ble_n, input logic bhe2_n, input logic ble2_n,
                          input logic [AW-1:0] a, input logic [15:0] d1, input logic [15:0] d2);
    _we = we_n; _oe = oe_n; _bhe = bhe_n; _ble = ble_n; _bhe2 = bhe2_n; _ble2 = ble2_n;
    address = a; data = d1; data2 = d2;
    c1 = 1'b1; c3 = 1'b0;
    tick();
    c1 = 1'b1; c3 = 1'b1;
    _we = 1'b1; _oe = 1'b1; _bhe = 1'b1; _ble = 1'b1; _bhe2 = 1'b1; _ble2 = 1'b1;
  endtask

  // Acts as the controller for one expected request.
  task automatic serve(input string tag, input logic we, input logic [AW-1:0] a,
                       input logic [1:0] bs, input logic [15:0] wd, input int pre_wait,
                       input int ack_dly, input int rv_dly, input logic [15:0] rd);
    int n;
    n = 0;
    while (!sd_req && n < 20) begin
      sd_ack = 1'($urandom_range(0, 1));  // stray ack while req is low
      tick();
      n++;
    end
    sd_ack = 1'b0;
    chk({tag, " req_wait"}, n, pre_wait);
    chk({tag, " we"}, sd_we, we);
    chk({tag, " addr"}, sd_addr, a);
    chk({tag, " bs"}, sd_bs, bs);
    if (we) chk({tag, " wdata"}, sd_wdata, wd);
    repeat (ack_dly) tick();
    if (ack_dly > 0) begin
      chk({tag, " req_held"}, sd_req, 1);
      chk({tag, " addr_held"}, sd_addr, a);
    end
    sd_ack = 1'b1;
    if (!we && rv_dly == 0) begin
      sd_rvalid = 1'b1; sd_rdata = rd;
    end else if (we) begin
      sd_rvalid = 1'($urandom_range(0, 1));  // stray rvalid during a write
      sd_rdata  = 16'($urandom);
    end
    tick();
    sd_ack = 1'b0; sd_rvalid = 1'b0;
    chk({tag, " req_drop"}, sd_req, 0);
    if (!we) begin
      if (rv_dly > 0) begin
        repeat (rv_dly - 1) tick();
        sd_rvalid = 1'b1; sd_rdata = rd;
        tick();
        sd_rvalid = 1'b0;
      end
      exp_ram = rd;
      chk({tag, " ramdata"}, ramdata_in, exp_ram);
    end
  endtask

  task automatic access(input logic we_n, input logic oe_n, input logic bhe_n,
                        input logic ble_n, input logic bhe2_n, input logic ble2_n,
                        input logic [AW-1:0] a, input logic [15:0] d1, input logic [15:0] d2,
                        input int ack_dly, input int rv_dly, input logic [15:0] rd);
    logic [1:0]    b1, b2;
    logic          is_wr, is_rd;
    logic [AW-1:0] a2;
    b1    = {!bhe_n, !ble_n};
    b2    = {!bhe2_n, !ble2_n};
    is_wr = !we_n && (b1 != 2'b00 || b2 != 2'b00);
    is_rd = !is_wr && !oe_n;
    a2    = a + 1'b1;
    q1_pulse(we_n, oe_n, bhe_n, ble_n, bhe2_n, ble2_n, a, d1, d2);
    if (is_wr) begin
      $display("txn write addr=%06h bs1=%b bs2=%b d1=%04h d2=%04h ack_dly=%0d", a, b1, b2, d1, d2, ack_dly);
      if (b1 != 2'b00) serve("wr1", 1'b1, a, b1, d1, 0, ack_dly, 0, 16'h0);
      if (b2 != 2'b00) serve("wr2", 1'b1, a2, b2, d2, (b1 != 2'b00) ? 1 : 0, ack_dly, 0, 16'h0);
      chk("wr ramdata_kept", ramdata_in, exp_ram);
    end else if (is_rd) begin
      $display("txn read  addr=%06h rdata=%04h ack_dly=%0d rv_dly=%0d", a, rd, ack_dly, rv_dly);
      serve("rd", 1'b0, a, 2'b11, 16'h0, 0, ack_dly, rv_dly, rd);
    end else begin
      $display("txn none  addr=%06h", a);
      chk("none req", sd_req, 0);
    end
    chk("txn busy", busy, 0);
    chk("txn late", late, 0);
    chk("txn late_cnt", late_cnt, exp_late);
  endtask

  // Read that the controller never acknowledges; optional Q0 and overlapping Q1.
  task automatic stall(input bit do_q0, input bit do_ovl, input bit detail);
    int hi;
    hi = 0;
    q1_pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 22'h0ABCDE, 16'h0, 16'h0);
    for (int i = 1; i < 40 && sd_req; i++) begin
      hi++;
      if (i == 2 && do_q0) begin c1 = 1'b0; c3 = 1'b0; end
      if (i == 4 && do_ovl) begin c1 = 1'b1; c3 = 1'b0; _oe = 1'b0; address = 22'h000555; end
      tick();
      c1 = 1'b1; c3 = 1'b1; _oe = 1'b1;
      if (detail && do_q0 && i == 2) chk("stall q0 late", late, 1);
      if (detail && do_q0 && i == 3) chk("stall late_one_cycle", late, 0);
      if (detail && do_ovl && i == 4) begin
        chk("stall ovl late", late, 1);
        chk("stall ovl addr", sd_addr, 22'h0ABCDE);
      end
    end
    exp_late = sat_late(exp_late + 1 + int'(do_q0) + int'(do_ovl));
    if (detail) begin
      $display("txn stall q0=%0d ovl=%0d req_cycles=%0d", do_q0, do_ovl, hi);
      chk("stall req_cycles", hi, 15);
      chk("stall timeout late", late, 1);
      chk("stall busy", busy, 0);
      chk("stall ramdata", ramdata_in, exp_ram);
    end
    chk("stall late_cnt", late_cnt, exp_late);
  endtask

  initial begin
    _reset = 1'b0; c1 = 1'b1; c3 = 1'b1;
    _we = 1'b1; _oe = 1'b1; _bhe = 1'b1; _ble = 1'b1; _bhe2 = 1'b1; _ble2 = 1'b1;
    address = '0; data = '0; data2 = '0;
    sd_ack = 1'b0; sd_rvalid = 1'b0; sd_rdata = '0;
    exp_ram = 16'h0; exp_late = 0;
    repeat (3) tick();
    chk("rst ramdata", ramdata_in, 0);
    chk("rst sd_req", sd_req, 0);
    chk("rst sd_we", sd_we, 0);
    chk("rst sd_addr", sd_addr, 0);
    chk("rst sd_bs", sd_bs, 0);
    chk("rst busy", busy, 0);
    chk("rst late", late, 0);
    chk("rst late_cnt", late_cnt, 0);
    _reset = 1'b1;
    tick();

    // Directed cases
    access(1, 0, 1, 1, 1, 1, 22'h000123, 16'h0, 16'h0, 2, 3, 16'hBEEF);
    access(0, 1, 0, 1, 0, 0, 22'h3FFFFF, 16'h1234, 16'h5678, 1, 0, 16'h0);
    access(0, 1, 1, 1, 1, 0, 22'h000010, 16'hDEAD, 16'hCAFE, 0, 0, 16'h0);
    access(0, 0, 1, 0, 1, 1, 22'h000200, 16'h7777, 16'h8888, 1, 0, 16'h0);
    access(1, 1, 0, 0, 0, 0, 22'h000300, 16'h1111, 16'h2222, 0, 0, 16'h0);
    access(0, 0, 1, 1, 1, 1, 22'h000400, 16'h0, 16'h0, 0, 0, 16'h4242);
    access(1, 0, 1, 1, 1, 1, 22'h001000, 16'h0, 16'h0, 0, 0, 16'h9ABC);

    // Random accesses
    for (int k = 0; k < 30; k++) begin
      access(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             AW'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 16'($urandom));
    end

    // Stalls, deadline misses, overlap and saturation
    stall(1'b1, 1'b0, 1'b1);
    stall(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 130; k++) stall(1'b1, 1'b0, 1'b0);
    chk("late_cnt saturated", late_cnt, 255);

    // Reset in the middle of a read
    q1_pulse(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 22'h000321, 16'h0, 16'h0);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    chk("midrst waiting", busy, 1);
    _reset = 1'b0;
    tick();
    exp_ram = 16'h0; exp_late = 0;
    chk("midrst sd_req", sd_req, 0);
    chk("midrst sd_addr", sd_addr, 0);
    chk("midrst sd_bs", sd_bs, 0);
    chk("midrst ramdata", ramdata_in, 0);
    chk("midrst late_cnt", late_cnt, 0);
    chk("midrst busy", busy, 0);
    _reset = 1'b1;
    sd_rvalid = 1'b1; sd_rdata = 16'hAAAA;
    tick();
    sd_rvalid = 1'b0;
    tick();
    $display("txn reset-mid-read stray rvalid");
    chk("post_rst ramdata", ramdata_in, exp_ram);
    chk("post_rst busy", busy, 0);
    chk("post_rst sd_req", sd_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
